ime_mv_ram_sp_ctl: RTL and testbench

- Parametrised single-port motion-vector RAM for IME; successor to the fixed 64x13 MV store.
- Adds a registered read-valid strobe, a read-data hold register, and a hardware clear sequencer that initialises every entry without the host driving addresses.
- Sits between the IME search engine (MV write-back) and the FME/MVP fetch path (MV read).

---
 rtl/ime_mv_ram_sp_ctl_pkg.sv | 15 +
 rtl/ime_mv_ram_sp_ctl_ram_1p.sv | 29 ++
 rtl/ime_mv_ram_sp_ctl.sv | 140 ++++++++++++++
 tb/tb_ime_mv_ram_sp_ctl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ime_mv_ram_sp_ctl_pkg.sv
// Shared definitions for the IME motion-vector RAM controller.
// Optional parity storage is selected with the IME_MV_RAM_PARITY_EN macro.
package ime_mv_ram_sp_ctl_pkg;

  // Default stored word width and address width (64 entries of 13 bits).
  localparam int MV_WD_DEF  = 13;
  localparam int ADR_WD_DEF = 6;

  // Controller states: host-accessible, or hardware clear in progress.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ime_mv_ram_sp_ctl_ram_1p.sv
// Behavioural single-port RAM.
// Low-active chip enable and write enable.
// The read output is registered and keeps its value between reads.
module ram_1p #(
  parameter int Word_Width = 13,
  parameter int Addr_Width = 6
) (
  input  logic                  clk,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [Addr_Width-1:0] adr,
  input  logic [Word_Width-1:0] din,
  output logic [Word_Width-1:0] dout
);

  logic [Word_Width-1:0] mem [0:(1<<Addr_Width)-1];

  // Single access per cycle: write when wen is low, otherwise read into dout.
  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!wen) begin
        mem[adr] <= din;
      end else begin
        dout <= mem[adr];
      end
    end
  end

endmodule

// File: rtl/ime_mv_ram_sp_ctl.sv
// Motion-vector store for IME: single-port RAM with a read-valid strobe,
// a read-data hold register, a collision strobe and a hardware clear sequencer.
// Define IME_MV_RAM_PARITY_EN to store an even-parity bit per word and
// to expose par_err_o.
module ime_mv_ram_sp_ctl
  import ime_mv_ram_sp_ctl_pkg::*;
#(
  parameter int               MV_WD   = MV_WD_DEF,
  parameter int               ADR_WD  = ADR_WD_DEF,
  parameter logic [MV_WD-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic [ADR_WD-1:0] adr_i,
  input  logic              wr_ena_i,
  input  logic [MV_WD-1:0]  wr_dat_i,
  input  logic              rd_ena_i,
  output logic [MV_WD-1:0]  rd_dat_o,
  output logic              rd_vld_o,
  output logic              busy_o,
`ifdef IME_MV_RAM_PARITY_EN
  output logic              par_err_o,
`endif
  output logic              col_o
);

`ifdef IME_MV_RAM_PARITY_EN
  localparam int SW = MV_WD + 1;
`else
  localparam int SW = MV_WD;
`endif

  state_t            state_reg, state_next;
  logic [ADR_WD-1:0] cnt_reg, cnt_next;
  logic              rd_vld_reg;
  logic              col_reg;
  logic [MV_WD-1:0]  hold_reg;

  logic              ram_cen, ram_wen;
  logic [ADR_WD-1:0] ram_adr;
  logic [SW-1:0]     ram_din, ram_dout;
  logic [SW-1:0]     host_word, clr_word;

  logic host_ok, wr_req, rd_req, col_req;

`ifdef IME_MV_RAM_PARITY_EN
  assign host_word = {^wr_dat_i, wr_dat_i};
  assign clr_word  = {^CLR_VAL, CLR_VAL};
`else
  assign host_word = wr_dat_i;
  assign clr_word  = CLR_VAL;
`endif

  // Host accesses are honoured only in IDLE and never while reset is held.
  assign host_ok = (state_reg == IDLE) && !rst;
  assign wr_req  = host_ok && !wr_ena_i;
  assign rd_req  = host_ok && !rd_ena_i && wr_ena_i;
  assign col_req = host_ok && !wr_ena_i && !rd_ena_i;

  // Next-state logic: start the clear on clr_i, walk every address once.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clr_i) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == '1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM port mux: the clear sequencer owns the port while busy; a write wins over a read.
  always_comb begin
    ram_cen = 1'b1;
    ram_wen = 1'b1;
    ram_adr = adr_i;
    ram_din = host_word;
    if (state_reg == CLEAR && !rst) begin
      ram_cen = 1'b0;
      ram_wen = 1'b0;
      ram_adr = cnt_reg;
      ram_din = clr_word;
    end else if (wr_req) begin
      ram_cen = 1'b0;
      ram_wen = 1'b0;
    end else if (rd_req) begin
      ram_cen = 1'b0;
    end
  end

  // State, counter, strobes and read-data hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rd_vld_reg <= 1'b0;
      col_reg    <= 1'b0;
      hold_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rd_vld_reg <= rd_req;
      col_reg    <= col_req;
      hold_reg   <= rd_dat_o;
    end
  end

  ram_1p #(
    .Word_Width (SW),
    .Addr_Width (ADR_WD)
  ) u_ram (
    .clk  (clk),
    .cen  (ram_cen),
    .wen  (ram_wen),
    .adr  (ram_adr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // Fresh RAM data in the completion cycle, otherwise the last completed read.
  assign rd_dat_o = rd_vld_reg ? ram_dout[MV_WD-1:0] : hold_reg;
  assign rd_vld_o = rd_vld_reg;
  assign busy_o   = (state_reg == CLEAR);
  assign col_o    = col_reg;

`ifdef IME_MV_RAM_PARITY_EN
  assign par_err_o = rd_vld_reg && ((^ram_dout[MV_WD-1:0]) != ram_dout[MV_WD]);
`endif

endmodule

// File: tb/tb_ime_mv_ram_sp_ctl.sv
// Scoreboard testbench for ime_mv_ram_sp_ctl (default 64 x 13, CLR_VAL = 0).
// Define IME_MV_RAM_PARITY_EN to also exercise the parity error output.
module tb_ime_mv_ram_sp_ctl;

  localparam int          AW    = 6;
  localparam int          DEPTH = 64;
  localparam logic [12:0] CLRV  = 13'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [5:0]  adr;
  logic        wr_ena;
  logic [12:0] wr_dat;
  logic        rd_ena;
  logic [12:0] rd_dat;
  logic        rd_vld;
  logic        busy;
  logic        col;
`ifdef IME_MV_RAM_PARITY_EN
  logic        par_err;
`endif

  ime_mv_ram_sp_ctl #(
    .MV_WD   (13),
    .ADR_WD  (AW),
    .CLR_VAL (CLRV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .adr_i    (adr),
    .wr_ena_i (wr_ena),
    .wr_dat_i (wr_dat),
    .rd_ena_i (rd_ena),
    .rd_dat_o (rd_dat),
    .rd_vld_o (rd_vld),
    .busy_o   (busy),
`ifdef IME_MV_RAM_PARITY_EN
    .par_err_o(par_err),
`endif
    .col_o    (col)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  typedef struct {
    int          cyc;
    logic [5:0]  a;
    logic [12:0] dat;
    logic        perr;
  } rd_exp_t;

  rd_exp_t     rq[$];
  int          cq[$];
  int          checks = 0;
  int          errors = 0;
  logic [12:0] ref_mem [DEPTH];

  // Monitor: every read strobe and collision strobe must match a queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_vld) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL rd_vld unexpected: cyc=%0d dat=%h required no read", cyc_cnt, rd_dat);
        end else begin
          rd_exp_t e;
          logic    pe;
          e = rq.pop_front();
          pe = 1'b0;
`ifdef IME_MV_RAM_PARITY_EN
          pe = par_err;
`endif
          if (rd_dat !== e.dat || cyc_cnt != e.cyc || pe !== e.perr) begin
            errors++;
            $display("FAIL rd_data: adr=%0d got dat=%h cyc=%0d perr=%b required dat=%h cyc=%0d perr=%b",
                     e.a, rd_dat, cyc_cnt, pe, e.dat, e.cyc, e.perr);
          end else begin
            $display("RD  cyc=%0d adr=%0d dat=%h perr=%b", cyc_cnt, e.a, rd_dat, pe);
          end
        end
      end
      if (col) begin
        checks++;
        if (cq.size() == 0) begin
          errors++;
          $display("FAIL col_o unexpected: cyc=%0d required no collision", cyc_cnt);
        end else begin
          int c;
          c = cq.pop_front();
          if (c != cyc_cnt) begin
            errors++;
            $display("FAIL col_timing: got cyc=%0d required cyc=%0d", cyc_cnt, c);
          end else begin
            $display("COL cyc=%0d", cyc_cnt);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    clr    = 1'b0;
    wr_ena = 1'b1;
    rd_ena = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic do_wr(input logic [5:0] a, input logic [12:0] d);
    adr = a; wr_dat = d; wr_ena = 1'b0; rd_ena = 1'b1;
    ref_mem[a] = d;
    $display("WR  cyc=%0d adr=%0d dat=%h", cyc_cnt + 1, a, d);
    cyc();
    idle_in();
  endtask

  task automatic do_rd(input logic [5:0] a, input logic perr);
    rd_exp_t e;
    e.cyc = cyc_cnt + 1; e.a = a; e.dat = ref_mem[a]; e.perr = perr;
    rq.push_back(e);
    adr = a; wr_ena = 1'b1; rd_ena = 1'b0;
    cyc();
    idle_in();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || cq.size() != 0) && n < 20) begin
      cyc();
      n++;
    end
    chk("drain_rd_queue", rq.size(), 0);
    chk("drain_col_queue", cq.size(), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) do_wr(6'(i), 13'($urandom));
  endtask

  initial begin
    int          n;
    logic [5:0]  la;
    logic [5:0]  a;
    logic [12:0] d;

    rst = 1'b1; adr = '0; wr_dat = '0;
    idle_in();
    repeat (3) cyc();
    chk("reset_rd_dat", rd_dat, 0);
    chk("reset_rd_vld", rd_vld, 0);
    chk("reset_busy", busy, 0);
    chk("reset_col", col, 0);
    rst = 1'b0;
    cyc();

    fill_random();

    // Write then read back, then hold for 10 idle cycles.
    do_wr(6'd5, 13'h1ABC);
    do_rd(6'd5, 1'b0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("hold_rd_dat", rd_dat, 13'h1ABC);
      chk("hold_rd_vld", rd_vld, 0);
      cyc();
    end

    // Collision on adr 9: write lands, read dropped.
    adr = 6'd9; wr_dat = 13'h0F0; wr_ena = 1'b0; rd_ena = 1'b0;
    ref_mem[9] = 13'h0F0;
    cq.push_back(cyc_cnt + 1);
    cyc();
    idle_in();
    cyc();
    do_rd(6'd9, 1'b0);
    drain();

    // Randomised back-to-back traffic with address reuse for read-after-write.
    la = 6'd0;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 1) == 0) ? la : 6'($urandom);
      d = 13'($urandom);
      adr = a; wr_dat = d; wr_ena = 1'b1; rd_ena = 1'b1;
      case ($urandom_range(0, 3))
        0: ;
        1: begin wr_ena = 1'b0; ref_mem[a] = d; end
        2: begin
          rd_exp_t e;
          e.cyc = cyc_cnt + 1; e.a = a; e.dat = ref_mem[a]; e.perr = 1'b0;
          rq.push_back(e);
          rd_ena = 1'b0;
        end
        default: begin
          wr_ena = 1'b0; rd_ena = 1'b0; ref_mem[a] = d;
          cq.push_back(cyc_cnt + 1);
        end
      endcase
      la = a;
      cyc();
    end
    idle_in();
    drain();

    // Clear with a same-cycle read; host traffic and clr_i during busy are ignored.
    do_wr(6'd3, 13'h0AA);
    clr = 1'b1;
    do_rd(6'd10, 1'b0);
    chk("busy_first_cycle", busy, 1);
    n = 0;
    while (busy && n < 300) begin
      n++;
      if (n == 5) begin
        adr = 6'd3; wr_dat = 13'h155; wr_ena = 1'b0; rd_ena = 1'b0; clr = 1'b1;
      end else begin
        idle_in();
      end
      cyc();
    end
    idle_in();
    chk("busy_cycles", n, 64);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = CLRV;
    do_rd(6'd0, 1'b0);
    do_rd(6'd31, 1'b0);
    do_rd(6'd63, 1'b0);
    do_rd(6'd3, 1'b0);
    drain();

    // Reset during clear cycle 20: entries 0..19 cleared, the rest untouched.
    fill_random();
    do_wr(6'd40, 13'h077);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (20) cyc();
    rst = 1'b1;
    cyc();
    chk("rst_mid_clear_busy", busy, 0);
    chk("rst_mid_clear_rd_dat", rd_dat, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) ref_mem[i] = CLRV;
    do_rd(6'd0, 1'b0);
    do_rd(6'd19, 1'b0);
    do_rd(6'd20, 1'b0);
    do_rd(6'd40, 1'b0);
    drain();

`ifdef IME_MV_RAM_PARITY_EN
    // Corrupt the stored parity bit of adr 7 and read it and a clean neighbour.
    do_wr(6'd7, 13'h0123);
    do_wr(6'd8, 13'h1357);
    dut.u_ram.mem[7][13] = ~dut.u_ram.mem[7][13];
    do_rd(6'd7, 1'b1);
    do_rd(6'd8, 1'b0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
